// File: rtl/gcd_pkg.sv
// ============================================================================
// Module   : gcd_pkg
// Purpose  : Shared state codes and defaults for the GCD job driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gcd_pkg;

  localparam int c_default_w   = 8;
  localparam int c_state_dbg_w = 3;

  typedef logic [c_state_dbg_w-1:0] state_t;

  // Codes also appear on state_dbg, so they are shared with the debug port.
  localparam state_t c_st_idle = 3'd0;
  localparam state_t c_st_clr  = 3'd1;
  localparam state_t c_st_go   = 3'd2;
  localparam state_t c_st_wait = 3'd3;
  localparam state_t c_st_resp = 3'd4;

endpackage

`default_nettype wire

// File: rtl/gcd_watchdog.sv
// ============================================================================
// Module   : gcd_watchdog
// Purpose  : Cycle counter with clear/enable and terminal count at TIMEOUT-1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gcd_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] c_tc_value = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;
  logic          w_tc;

  assign w_tc = (r_count == c_tc_value);
  assign tc   = w_tc;

  // Saturates at the terminal value so tc stays asserted until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !w_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gcd_job_driver.sv
// ============================================================================
// Module   : gcd_job_driver
// Purpose  : Feeds operand pairs to a GCD core and returns results downstream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gcd_job_driver
  import gcd_pkg::*;
#(
  parameter int W       = c_default_w,
  parameter int TIMEOUT = 1024,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_gcd,
  output logic         out_err,
  output logic         core_rst,
  output logic         core_go,
  output logic [W-1:0] core_a,
  output logic [W-1:0] core_b,
  input  logic         core_done,
  input  logic [W-1:0] core_result,
  output logic         busy,
  output logic [2:0]   state_dbg
);

  state_t         r_state;
  state_t         w_next;
  logic           w_accept;
  logic           w_a_zero;
  logic           w_b_zero;
  logic           w_wd_tc;
  logic           w_core_rst;
  logic           w_in_ready;
  logic           r_out_valid;
  logic [W-1:0]   r_out_gcd;
  logic           r_out_err;
  logic           r_core_go;
  logic [W-1:0]   r_core_a;
  logic [W-1:0]   r_core_b;
  logic           r_busy;

  assign w_accept = in_valid && w_in_ready;
  assign w_a_zero = (in_a == '0);
  assign w_b_zero = (in_b == '0);

  gcd_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (r_state == c_st_go),
    .en    (r_state == c_st_wait),
    .tc    (w_wd_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_next = (w_a_zero || w_b_zero) ? c_st_resp : c_st_clr;
      c_st_clr:  w_next = c_st_go;
      c_st_go:   w_next = c_st_wait;
      c_st_wait: if (core_done || w_wd_tc) w_next = c_st_resp;
      c_st_resp: if (out_ready) w_next = c_st_idle;
      default:   w_next = c_st_idle;
    endcase
  end

  // Unregistered decodes; both must be forced during reset.
  always_comb begin
    w_core_rst = !rst_n || (r_state == c_st_clr);
    w_in_ready = rst_n && (r_state == c_st_idle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_gcd   <= '0;
      r_out_err   <= 1'b0;
      r_core_go   <= 1'b0;
      r_core_a    <= '0;
      r_core_b    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= (w_next == c_st_resp);
      r_core_go   <= (w_next == c_st_go);
      r_busy      <= (w_next != c_st_idle);
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            if (w_a_zero || w_b_zero) begin
              r_out_gcd <= w_a_zero ? in_b : in_a;
              r_out_err <= w_a_zero && w_b_zero;
            end else begin
              r_core_a <= in_a;
              r_core_b <= in_b;
            end
          end
        end
        c_st_wait: begin
          if (core_done) begin
            r_out_gcd <= core_result;
            r_out_err <= 1'b0;
          end else if (w_wd_tc) begin
            r_out_gcd <= '0;
            r_out_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign core_rst  = w_core_rst;
  assign out_valid = r_out_valid;
  assign out_gcd   = r_out_gcd;
  assign out_err   = r_out_err;
  assign core_go   = r_core_go;
  assign core_a    = r_core_a;
  assign core_b    = r_core_b;
  assign busy      = r_busy;
  assign state_dbg = r_state;

endmodule

`default_nettype wire

// File: tb/tb_gcd_job_driver.sv
// ============================================================================
// Module   : tb_gcd_job_driver
// Purpose  : Directed self-checking bench with a behavioural subtractive GCD core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gcd_job_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_gcd;
  logic       out_err;
  logic       core_rst;
  logic       core_go;
  logic [7:0] core_a;
  logic [7:0] core_b;
  logic       core_done;
  logic [7:0] core_result;
  logic       busy;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int go_count = 0;

  // Core model: subtract until equal; done holds until core_rst.
  logic       stub = 1'b0;
  logic [7:0] m_x = '0;
  logic [7:0] m_y = '0;
  logic [7:0] m_res = '0;
  logic       m_run = 1'b0;
  logic       m_done = 1'b0;

  assign core_done   = m_done && !stub;
  assign core_result = m_res;

  always #5 clk = ~clk;

  gcd_job_driver #(.W(8), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_gcd     (out_gcd),
    .out_err     (out_err),
    .core_rst    (core_rst),
    .core_go     (core_go),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  always @(posedge clk) begin
    if (core_rst) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
    end else if (core_go) begin
      m_x   <= core_a;
      m_y   <= core_b;
      m_run <= 1'b1;
    end else if (m_run) begin
      if (m_x == m_y) begin
        m_done <= 1'b1;
        m_res  <= m_x;
        m_run  <= 1'b0;
      end else if (m_x > m_y) begin
        m_x <= m_x - m_y;
      end else begin
        m_y <= m_y - m_x;
      end
    end
  end

  always @(posedge clk) if (core_go === 1'b1) go_count <= go_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag, input int budget);
    int n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, out_valid, 1);
  endtask

  initial begin
    int go0;
    int waits;
    int seen;

    // Reset state
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_state", state_dbg, 0);
    check("rst_core_go", core_go, 0);
    step();
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_core_rst", core_rst, 0);
    check("idle_busy", busy, 0);

    // Job (48,18) through the core
    out_ready = 1'b1;
    go0 = go_count;
    in_valid = 1'b1; in_a = 8'd48; in_b = 8'd18;
    step();
    in_valid = 1'b0;
    check("t1_clr_core_rst", core_rst, 1);
    check("t1_clr_state", state_dbg, 1);
    check("t1_clr_core_go", core_go, 0);
    check("t1_clr_in_ready", in_ready, 0);
    step();
    check("t1_go_core_go", core_go, 1);
    check("t1_go_core_rst", core_rst, 0);
    check("t1_go_core_a", core_a, 48);
    check("t1_go_core_b", core_b, 18);
    step();
    check("t1_wait_core_go", core_go, 0);
    check("t1_wait_state", state_dbg, 3);
    wait_out("t1_out_valid", 40);
    check("t1_gcd", out_gcd, 6);
    check("t1_err", out_err, 0);
    check("t1_go_pulses", go_count - go0, 1);
    step();
    check("t1_done_valid", out_valid, 0);
    check("t1_done_state", state_dbg, 0);

    // Zero-operand bypass
    go0 = go_count;
    in_valid = 1'b1; in_a = 8'd0; in_b = 8'd35;
    step();
    in_valid = 1'b0;
    check("t2_valid", out_valid, 1);
    check("t2_gcd", out_gcd, 35);
    check("t2_err", out_err, 0);
    check("t2_core_rst", core_rst, 0);
    step();
    check("t2_valid_drop", out_valid, 0);
    in_valid = 1'b1; in_a = 8'd0; in_b = 8'd0;
    step();
    in_valid = 1'b0;
    check("t2z_valid", out_valid, 1);
    check("t2z_gcd", out_gcd, 0);
    check("t2z_err", out_err, 1);
    step();
    check("t2_no_go", go_count - go0, 0);

    // Downstream backpressure with (21,14)
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'd21; in_b = 8'd14;
    step();
    in_valid = 1'b0;
    wait_out("t3_out_valid", 40);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_gcd", out_gcd, 7);
      check("t3_hold_in_ready", in_ready, 0);
      check("t3_hold_busy", busy, 1);
      step();
    end
    check("t3_still_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    check("t3_idle_state", state_dbg, 0);
    check("t3_idle_valid", out_valid, 0);

    // Watchdog: core never finishes
    stub = 1'b1;
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd6;
    step();
    in_valid = 1'b0;
    step();
    step();
    waits = 0;
    while (state_dbg == 3'd3 && waits < 40) begin
      waits++;
      step();
    end
    check("t4_wait_cycles", waits, 16);
    check("t4_valid", out_valid, 1);
    check("t4_gcd", out_gcd, 0);
    check("t4_err", out_err, 1);
    step();
    stub = 1'b0;
    step();
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd6;
    step();
    in_valid = 1'b0;
    check("t4b_clr_pulse", core_rst, 1);
    step();
    check("t4b_clr_end", core_rst, 0);
    wait_out("t4b_out_valid", 40);
    check("t4b_gcd", out_gcd, 3);
    check("t4b_err", out_err, 0);
    step();

    // Reset in the middle of WAIT
    in_valid = 1'b1; in_a = 8'd100; in_b = 8'd75;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("t5_in_wait", state_dbg, 3);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_core_rst", core_rst, 1);
    check("t5_rst_state", state_dbg, 0);
    check("t5_rst_core_a", core_a, 0);
    check("t5_rst_in_ready", in_ready, 0);
    check("t5_rst_busy", busy, 0);
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    check("t5_no_response", seen, 0);
    in_valid = 1'b1; in_a = 8'd100; in_b = 8'd75;
    step();
    in_valid = 1'b0;
    wait_out("t5b_out_valid", 40);
    check("t5b_gcd", out_gcd, 25);
    check("t5b_err", out_err, 0);
    step();

    // Back-to-back jobs with in_valid held
    go0 = go_count;
    in_valid = 1'b1; in_a = 8'd12; in_b = 8'd8;
    step();
    in_a = 8'd17; in_b = 8'd5;
    wait_out("t6a_out_valid", 40);
    check("t6a_gcd", out_gcd, 4);
    check("t6a_go_pulses", go_count - go0, 1);
    step();
    wait_out("t6b_out_valid", 40);
    in_valid = 1'b0;
    check("t6b_gcd", out_gcd, 1);
    check("t6b_err", out_err, 0);
    check("t6_go_pulses", go_count - go0, 2);
    step();
    check("t6_end_state", state_dbg, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "bench timed out");
  end

endmodule

`default_nettype wire
